// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory that answers one request at a time over a
// valid/ready request channel and a valid/ready response channel. Each
// request is followed by WAIT wait-state cycles, then a response.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset (memory contents kept)
//   req_valid  : initiator presents a request
//   req_ready  : responder can accept a request this cycle (IDLE only)
//   req_we     : 1 = write, 0 = read
//   req_addr   : byte address; word index is addr[31:2]
//   req_wdata  : write data
//   req_be     : byte-lane enables for writes
//   rsp_valid  : response present
//   rsp_ready  : initiator accepts the response
//   rsp_rdata  : read data, 0 for writes and errored accesses
//   rsp_err    : access was misaligned or out of range
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  // The enumerators carry an S_ prefix because WAIT is already the
  // wait-state parameter name.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  // req_ready is gated with rst_n so it drops the moment reset asserts.
  // Gating accept the same way keeps a request presented during reset from
  // reaching memory in the zero-wait configuration.
  assign req_ready = rst_n && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state logic: IDLE waits for a request, WAIT counts down the
  // configured wait states, RESP holds the response until it is taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The memory access happens on the edge that enters RESP. With no wait
  // states that is the accept edge itself, so the live request fields are
  // used; otherwise the fields captured at accept are used.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign enter_resp = (state_q != S_RESP) && (state_d == S_RESP);
  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
  assign acc_idx    = acc_addr[AW+1:2];

  // Response data is formed once on entry to RESP and then held, so it stays
  // stable however long the initiator stalls.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
    end
  end

  // Control and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Storage is never reset. Errored writes are dropped; a reset during WAIT
  // forces IDLE so enter_resp never fires for the abandoned request.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. The main instance uses DEPTH=256,
// WAIT=2; a second instance with WAIT=0 covers the zero-wait-state
// throughput case.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WAIT_TB = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_be;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] rsp0_rdata;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(256), .WAIT(WAIT_TB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH(256), .WAIT(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req0_valid),
    .req_ready (req0_ready),
    .req_we    (req0_we),
    .req_addr  (req0_addr),
    .req_wdata (req0_wdata),
    .req_be    (req0_be),
    .rsp_valid (rsp0_valid),
    .rsp_ready (rsp0_ready),
    .rsp_rdata (rsp0_rdata),
    .rsp_err   (rsp0_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction on the WAIT=2 instance, started at #1 after an
  // edge while IDLE. Request fields are scrambled (with req_valid still high)
  // once accepted, to show they are ignored outside accept. earlyReady holds
  // rsp_ready high from the start; otherwise the response is stalled for
  // hold cycles before being taken.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int hold, input bit earlyReady,
                               input string tag, input logic [31:0] expData, input logic expErr);
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = earlyReady;
    checkOutput({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      checkOutput({tag, ":busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, ":latency"}, 32'(lat), 32'(WAIT_TB + 1));
    checkOutput({tag, ":rdata"}, rsp_rdata, expData);
    checkOutput({tag, ":err"}, 32'(rsp_err), 32'(expErr));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, ":hold_rdata"}, rsp_rdata, expData);
      checkOutput({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ":done_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Directed sequence: reset, write/read, byte enables, errors, stalls,
  // resets mid-transaction, then the zero-wait instance.
  initial begin
    int nValid;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'd0;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req0_we    = 1'b0;
    req0_addr  = 32'd0;
    req0_wdata = 32'd0;
    req0_be    = 4'd0;
    rsp0_ready = 1'b0;

    #1;
    checkOutput("reset:req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset:rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset:rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset:req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release:req_ready", 32'(req_ready), 32'd1);
    checkOutput("release:rsp_valid", 32'(rsp_valid), 32'd0);

    // Plain write then read back.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "wr10", 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "rd10", 32'hDEADBEEF, 1'b0);

    // Partial byte-lane write: lanes 0 and 2 take the new bytes.
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, "wr20a", 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 1'b0, "wr20b", 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, "rd20", 32'h11BB33DD, 1'b0);
    // No enabled lanes: still responds, changes nothing.
    applyStimulus(1'b1, 32'h20, 32'h55555555, 4'h0, 0, 1'b0, "wr20be0", 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "rd20b", 32'h11BB33DD, 1'b0);

    // Error cases, with word 0 seeded to detect any stray write.
    applyStimulus(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 1'b0, "wr0", 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 0, 1'b0, "wr402", 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 1'b0, "wr400", 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h400, 32'h0, 4'hF, 0, 1'b0, "rd400", 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 0, 1'b0, "wr002", 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h3, 32'h0, 4'hF, 0, 1'b0, "rd003", 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, "rd0", 32'hCAFEF00D, 1'b0);

    // Highest valid word, with rsp_ready already high before RESP.
    applyStimulus(1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, 0, 1'b1, "wr3fc", 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h3FC, 32'h0, 4'hF, 0, 1'b1, "rd3fc", 32'h0BADCAFE, 1'b0);

    // Backpressure: response held for five cycles.
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, "bp", 32'hDEADBEEF, 1'b0);

    // Reset one cycle after accepting a write: the write must be abandoned.
    applyStimulus(1'b1, 32'h30, 32'h0, 4'hF, 0, 1'b0, "wr30", 32'd0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hFFFFFFFF;
    req_be    = 4'hF;
    checkOutput("rstwait:req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstwait:rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstwait:req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nValid = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) nValid++;
    end
    checkOutput("rstwait:no_rsp", 32'(nValid), 32'd0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, "rd30", 32'd0, 1'b0);

    // Reset while a response is pending: it is dropped immediately.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nValid = 0;
    while (!rsp_valid && nValid < 20) begin
      @(posedge clk); #1;
      nValid++;
    end
    checkOutput("rstresp:rdata", rsp_rdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    checkOutput("rstresp:rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstresp:rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstresp:after_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstresp:after_ready", 32'(req_ready), 32'd1);

    // Zero wait states: one-cycle latency, one transaction every 2 cycles.
    req0_valid = 1'b1;
    req0_we    = 1'b1;
    req0_addr  = 32'h8;
    req0_wdata = 32'h12345678;
    req0_be    = 4'hF;
    rsp0_ready = 1'b1;
    checkOutput("w0:req_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("w0:latency1", 32'(rsp0_valid), 32'd1);
    checkOutput("w0:err", 32'(rsp0_err), 32'd0);
    checkOutput("w0:rdata", rsp0_rdata, 32'd0);
    req0_we = 1'b0;
    @(posedge clk); #1;
    checkOutput("w0:done_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("w0:done_ready", 32'(req0_ready), 32'd1);
    nValid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp0_valid) begin
        nValid++;
        checkOutput("r0:rdata", rsp0_rdata, 32'h12345678);
      end
    end
    checkOutput("r0:count", 32'(nValid), 32'd4);
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
